// File: rtl/bank_pkg.sv
// Shared types and default sizing for the bank router and the banks attached to it.
package bank_pkg;
   localparam int NODE_W        = 15;
   localparam int CNT_W         = 48;
   localparam int NUM_BANKS_DEF = 4;
   localparam int PKT_W         = NODE_W + CNT_W;

   // dst_node is three 5-bit letters; its low bits select the destination bank
   typedef struct packed {
      logic [NODE_W-1:0] dst_node;
      logic [CNT_W-1:0]  count;
   } pkt_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the winner only when a grant is taken.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);
   localparam int PTR_W = $clog2(N);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] idx;
   logic             found;

   // N is a power of two, so the pointer wraps naturally at PTR_W bits
   always_comb begin
      grant    = '0;
      ptr_next = ptr;
      found    = 1'b0;
      idx      = '0;
      for (int k = 0; k < N; k++) begin
         idx = ptr + PTR_W'(k);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_next   = idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= ptr_next;
      end
   end
endmodule

// File: rtl/bank_router.sv
// Crossbar between NUM_BANKS banks: one-entry output register per destination,
// round-robin arbitration per output, single-cycle latency.
module bank_router #(
   parameter int NUM_BANKS = bank_pkg::NUM_BANKS_DEF,
   parameter int CNT_W     = bank_pkg::CNT_W
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [NUM_BANKS-1:0]                              bank_valid_in,
   output logic [NUM_BANKS-1:0]                              bank_ready_in,
   input  logic [NUM_BANKS-1:0][bank_pkg::NODE_W+CNT_W-1:0]  bank_pkt_in,
   output logic [NUM_BANKS-1:0]                              bank_valid_out,
   input  logic [NUM_BANKS-1:0]                              bank_ready_out,
   output logic [NUM_BANKS-1:0][bank_pkg::NODE_W+CNT_W-1:0]  bank_pkt_out,
   output logic                                              busy,
   output logic [31:0]                                       pkt_count
);
   import bank_pkg::*;

   localparam int SEL_W  = $clog2(NUM_BANKS);
   localparam int WIDTH  = NODE_W + CNT_W;

   logic [NUM_BANKS-1:0]                  full;
   logic [NUM_BANKS-1:0]                  open_out;
   logic [NUM_BANKS-1:0][WIDTH-1:0]       data;
   logic [NUM_BANKS-1:0][WIDTH-1:0]       sel_pkt;
   logic [NUM_BANKS-1:0][SEL_W-1:0]       dst;
   logic [NUM_BANKS-1:0][NUM_BANKS-1:0]   req;   // [output][input]
   logic [NUM_BANKS-1:0][NUM_BANKS-1:0]   grant; // [output][input]
   logic [NUM_BANKS-1:0]                  ready_int;
   logic [31:0]                           drained;

   // an output can take a new packet if empty or being drained this cycle
   assign open_out = ~full | bank_ready_out;

   always_comb begin
      dst = '0;
      req = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         dst[i] = bank_pkt_in[i][CNT_W +: SEL_W];
      end
      for (int j = 0; j < NUM_BANKS; j++) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            req[j][i] = bank_valid_in[i] && open_out[j] && !rst && (dst[i] == SEL_W'(j));
         end
      end
   end

   for (genvar j = 0; j < NUM_BANKS; j++) begin : g_arb
      rr_arbiter #(.N(NUM_BANKS)) u_arb (
         .clk     (clk),
         .rst     (rst),
         .req     (req[j]),
         .advance (open_out[j]),
         .grant   (grant[j])
      );
   end

   always_comb begin
      sel_pkt   = '0;
      ready_int = '0;
      for (int j = 0; j < NUM_BANKS; j++) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (grant[j][i]) begin
               sel_pkt[j]   = bank_pkt_in[i];
               ready_int[i] = 1'b1;
            end
         end
      end
   end

   assign drained = 32'($countones(full & bank_ready_out));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full      <= '0;
         data      <= '0;
         pkt_count <= '0;
      end else begin
         for (int j = 0; j < NUM_BANKS; j++) begin
            if (|grant[j]) begin
               full[j] <= 1'b1;
               data[j] <= sel_pkt[j];
            end else if (bank_ready_out[j]) begin
               full[j] <= 1'b0;
            end
         end
         pkt_count <= pkt_count + drained;
      end
   end

   assign bank_ready_in  = ready_int;
   assign bank_valid_out = full;
   assign bank_pkt_out   = data;
   assign busy           = (|full) | (|bank_valid_in);
endmodule

// File: tb/tb_bank_router.sv
// Bench for bank_router: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural crossbar model.
module tb_bank_router;
   import bank_pkg::*;

   localparam int N = 4;

   logic                  clk;
   logic                  rst;
   logic [N-1:0]          bank_valid_in;
   logic [N-1:0]          bank_ready_in;
   logic [N-1:0][PKT_W-1:0] bank_pkt_in;
   logic [N-1:0]          bank_valid_out;
   logic [N-1:0]          bank_ready_out;
   logic [N-1:0][PKT_W-1:0] bank_pkt_out;
   logic                  busy;
   logic [31:0]           pkt_count;

   int n_checks = 0;
   int n_err    = 0;

   // model state: one slot per output, a pointer per output, a delivery counter
   bit          m_full [N];
   pkt_t        m_pkt  [N];
   int          m_ptr  [N];
   logic [31:0] m_count;
   bit          nx_full [N];
   pkt_t        nx_pkt  [N];
   int          nx_ptr  [N];
   logic [31:0] nx_count;
   logic [N-1:0] m_exp_ready;

   bank_router #(.NUM_BANKS(N), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .bank_valid_in  (bank_valid_in),
      .bank_ready_in  (bank_ready_in),
      .bank_pkt_in    (bank_pkt_in),
      .bank_valid_out (bank_valid_out),
      .bank_ready_out (bank_ready_out),
      .bank_pkt_out   (bank_pkt_out),
      .busy           (busy),
      .pkt_count      (pkt_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin
         m_full[j] = 0;
         m_pkt[j]  = '0;
         m_ptr[j]  = 0;
      end
      m_count     = '0;
      m_exp_ready = '0;
   endtask

   function automatic int dst_bank(input int i);
      pkt_t p;
      p = pkt_t'(bank_pkt_in[i]);
      return int'(p.dst_node) % N;
   endfunction

   // Sample at the falling edge: compare against the model, then work out the
   // model's state for after the coming rising edge.
   task automatic settle();
      int  g;
      int  cand;
      bit  any_full;
      @(negedge clk);
      m_exp_ready = '0;
      any_full    = 0;
      nx_count    = m_count;
      for (int j = 0; j < N; j++) begin
         nx_full[j] = m_full[j];
         nx_pkt[j]  = m_pkt[j];
         nx_ptr[j]  = m_ptr[j];
         if (m_full[j]) any_full = 1;
         if (m_full[j] && bank_ready_out[j]) nx_count = nx_count + 1;
         g = -1;
         if (!m_full[j] || bank_ready_out[j]) begin
            for (int k = 0; k < N; k++) begin
               cand = (m_ptr[j] + k) % N;
               if (g < 0 && bank_valid_in[cand] && dst_bank(cand) == j) g = cand;
            end
         end
         if (g >= 0) begin
            m_exp_ready[g] = 1'b1;
            nx_full[j] = 1;
            nx_pkt[j]  = pkt_t'(bank_pkt_in[g]);
            nx_ptr[j]  = (g + 1) % N;
         end else if (bank_ready_out[j]) begin
            nx_full[j] = 0;
         end
      end
      check("ready_in", 64'(bank_ready_in), 64'(m_exp_ready));
      for (int j = 0; j < N; j++) begin
         check("valid_out", 64'(bank_valid_out[j]), 64'(m_full[j]));
         if (m_full[j]) check("pkt_out", 64'(bank_pkt_out[j]), 64'(m_pkt[j]));
      end
      check("pkt_count", 64'(pkt_count), 64'(m_count));
      check("busy", 64'(busy), 64'(any_full || (|bank_valid_in)));
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) begin
         m_full[j] = nx_full[j];
         m_pkt[j]  = nx_pkt[j];
         m_ptr[j]  = nx_ptr[j];
      end
      m_count = nx_count;
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   function automatic logic [PKT_W-1:0] mk(input int dst, input int cnt);
      pkt_t p;
      p.dst_node = NODE_W'(dst);
      p.count    = CNT_W'(cnt);
      return p;
   endfunction

   function automatic logic [PKT_W-1:0] rnd_pkt();
      return {15'($urandom), 16'($urandom), 32'($urandom)};
   endfunction

   initial begin
      logic [N-1:0] acc;
      bit           got3;
      rst            = 1'b1;
      bank_valid_in  = '0;
      bank_ready_out = '0;
      bank_pkt_in    = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_out", 64'(bank_valid_out), 64'h0);
      check("rst_pkt_count", 64'(pkt_count), 64'h0);
      check("rst_ready_in", 64'(bank_ready_in), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      bank_valid_in = 4'b0010;
      #1;
      check("rst_ready_in_held", 64'(bank_ready_in), 64'h0);
      check("rst_busy_valid", 64'(busy), 64'h1);
      bank_valid_in = '0;
      rst = 1'b0;

      // single packet, bank 0 -> bank 1
      bank_ready_out = 4'hf;
      bank_valid_in  = 4'b0001;
      bank_pkt_in[0] = mk(15'h0005, 7);
      settle();
      check("single_ready", 64'(bank_ready_in), 64'h1);
      advance();
      bank_valid_in = '0;
      settle();
      check("single_valid_out", 64'(bank_valid_out), 64'h2);
      check("single_count", 64'(bank_pkt_out[1][CNT_W-1:0]), 64'd7);
      advance();
      check("single_pkt_count", 64'(pkt_count), 64'd1);

      // contention: everyone to bank 2
      for (int i = 0; i < N; i++) bank_pkt_in[i] = mk(2, 100 + i);
      bank_valid_in = 4'hf;
      for (int c = 0; c < N; c++) begin
         settle();
         check("cont_grant", 64'(bank_ready_in), 64'(1 << c));
         if (c > 0) begin
            check("cont_valid", 64'(bank_valid_out[2]), 64'h1);
            check("cont_count", 64'(bank_pkt_out[2][CNT_W-1:0]), 64'(100 + c - 1));
         end
         advance();
         bank_valid_in[c] = 1'b0;
      end
      settle();
      check("cont_last", 64'(bank_pkt_out[2][CNT_W-1:0]), 64'd103);
      advance();

      // backpressure on output 3
      bank_ready_out = 4'b0111;
      bank_valid_in  = 4'b0010;
      bank_pkt_in[1] = mk(3, 55);
      settle();
      check("bp_first_grant", 64'(bank_ready_in), 64'h2);
      advance();
      bank_valid_in  = 4'b0100;
      bank_pkt_in[2] = mk(3, 66);
      repeat (5) begin
         settle();
         check("bp_hold", 64'(bank_pkt_out[3][CNT_W-1:0]), 64'd55);
         check("bp_no_ready", 64'(bank_ready_in[2]), 64'h0);
         advance();
      end
      bank_ready_out = 4'hf;
      settle();
      check("bp_refill", 64'(bank_ready_in), 64'h4);
      advance();
      bank_valid_in = '0;
      settle();
      check("bp_resume", 64'(bank_pkt_out[3][CNT_W-1:0]), 64'd66);
      check("bp_resume_valid", 64'(bank_valid_out[3]), 64'h1);
      advance();

      // parallel permutation
      for (int i = 0; i < N; i++) bank_pkt_in[i] = mk((i + 1) % N, 200 + i);
      bank_valid_in = 4'hf;
      settle();
      check("par_ready", 64'(bank_ready_in), 64'hf);
      advance();
      bank_valid_in = '0;
      settle();
      check("par_valid", 64'(bank_valid_out), 64'hf);
      check("par_pkt0", 64'(bank_pkt_out[0][CNT_W-1:0]), 64'd203);
      advance();
      check("par_pkt_count", 64'(pkt_count), 64'd11);

      // randomized traffic; a bank holds its packet until accepted
      for (int i = 0; i < N; i++) begin
         bank_valid_in[i] = 1'($urandom);
         bank_pkt_in[i]   = rnd_pkt();
      end
      for (int t = 0; t < 3000; t++) begin
         if (t % 200 < 20) bank_ready_out = 4'($urandom) & 4'($urandom);
         else              bank_ready_out = 4'($urandom) | 4'($urandom);
         settle();
         acc = m_exp_ready;
         advance();
         for (int i = 0; i < N; i++) begin
            if (bank_valid_in[i] && acc[i]) begin
               bank_valid_in[i] = ($urandom_range(3) != 0);
               bank_pkt_in[i]   = rnd_pkt();
            end else if (!bank_valid_in[i] && $urandom_range(1) == 1) begin
               bank_valid_in[i] = 1'b1;
               bank_pkt_in[i]   = rnd_pkt();
            end
         end
      end

      // reset with outputs 0 and 2 full
      bank_valid_in  = '0;
      bank_ready_out = 4'hf;
      repeat (2) cycle();
      bank_ready_out = '0;
      bank_pkt_in[0] = mk(0, 300);
      bank_pkt_in[1] = mk(2, 301);
      bank_valid_in  = 4'b0011;
      cycle();
      settle();
      check("mid_full", 64'(bank_valid_out), 64'h5);
      rst = 1'b1;
      #1;
      model_reset();
      check("mid_valid_out", 64'(bank_valid_out), 64'h0);
      check("mid_pkt_out", 64'(bank_pkt_out), 64'h0);
      check("mid_pkt_count", 64'(pkt_count), 64'h0);
      check("mid_ready_in", 64'(bank_ready_in), 64'h0);
      check("mid_busy_in", 64'(busy), 64'h1);
      bank_valid_in = '0;
      #1;
      check("mid_busy_low", 64'(busy), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // fairness: bank 0 streams to 1, bank 3 offers once
      bank_ready_out = 4'hf;
      bank_valid_in  = 4'b0001;
      bank_pkt_in[0] = mk(1, 400);
      cycle();
      bank_pkt_in[0] = mk(1, 401);
      bank_valid_in  = 4'b1001;
      bank_pkt_in[3] = mk(1, 999);
      got3 = 0;
      for (int w = 0; w < 3 && !got3; w++) begin
         settle();
         if (bank_ready_in[3]) begin
            got3 = 1;
            check("fair_first", 64'(w), 64'd0);
         end
         advance();
         if (got3) bank_valid_in[3] = 1'b0;
         if (acc[0]) bank_pkt_in[0] = mk(1, 402 + w);
      end
      check("fair_granted", 64'(got3), 64'h1);
      settle();
      check("fair_delivered", 64'(bank_pkt_out[1][CNT_W-1:0]), 64'd999);
      advance();
      bank_valid_in = '0;
      repeat (3) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
